// File: rtl/lives_tracker_pkg.sv
// lives_tracker_pkg: shared state, winner codes and widths for the lives tracker
// Optional build macro LIVES_TRACKER_HEAL_EN is consumed by the other files.
package lives_tracker_pkg;
  localparam int LIFE_W = 4;
  localparam logic [LIFE_W-1:0] ONE_LIFE = 1;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  function automatic logic [1:0] winner_of(logic p1_out, logic p2_out);
    return (p1_out && p2_out) ? WIN_DRAW : p2_out ? WIN_P1 : p1_out ? WIN_P2 : WIN_NONE;
  endfunction
endpackage

// File: rtl/lives_tracker_if.sv
// lives_tracker_if: game-side bus of the lives tracker
// master: drives VGA_VS, game_on, game_over, p1_hit, p2_hit (and p1_heal/p2_heal
// when LIVES_TRACKER_HEAL_EN is defined); reads lives, invuln flags, round_winner.
// slave: the tracker itself, opposite directions.
interface lives_tracker_if;
  import lives_tracker_pkg::*;
  logic VGA_VS;
  logic game_on;
  logic game_over;
  logic p1_hit;
  logic p2_hit;
`ifdef LIVES_TRACKER_HEAL_EN
  logic p1_heal;
  logic p2_heal;
`endif
  logic [LIFE_W-1:0] player1_lives;
  logic [LIFE_W-1:0] player2_lives;
  logic p1_invuln;
  logic p2_invuln;
  logic [1:0] round_winner;
  modport master (
`ifdef LIVES_TRACKER_HEAL_EN
    output p1_heal, p2_heal,
`endif
    output VGA_VS, game_on, game_over, p1_hit, p2_hit,
    input player1_lives, player2_lives, p1_invuln, p2_invuln, round_winner
  );
  modport slave (
`ifdef LIVES_TRACKER_HEAL_EN
    input p1_heal, p2_heal,
`endif
    input VGA_VS, game_on, game_over, p1_hit, p2_hit,
    output player1_lives, player2_lives, p1_invuln, p2_invuln, round_winner
  );
endinterface

// File: rtl/lives_tracker_invuln_timer.sv
// invuln_timer: per-player frame down-counter for post-hit immunity
// Ports: Clk, Reset (async active-low), clear (to zero, wins), load (to FRAMES),
// tick (decrement while nonzero), active (registered counter != 0).
module invuln_timer #(
  parameter logic [7:0] FRAMES = 8'd60
) (
  input logic Clk,
  input logic Reset,
  input logic clear,
  input logic load,
  input logic tick,
  output logic active
);
  logic [7:0] cnt, cnt_next;
  always_comb cnt_next = clear ? 8'd0 : load ? FRAMES : (tick && cnt != 8'd0) ? cnt - 8'd1 : cnt;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      cnt <= 8'd0;
      active <= 1'b0;
    end else begin
      cnt <= cnt_next;
      active <= cnt_next != 8'd0;
    end
endmodule

// File: rtl/lives_tracker.sv
// lives_tracker: both players' lives, hit immunity and round winner latch
// Ports: Clk, Reset (async active-low), bus (lives_tracker_if.slave).
// Build macro LIVES_TRACKER_HEAL_EN adds heal pulses and the MAX_LIVES ceiling.
module lives_tracker
  import lives_tracker_pkg::*;
#(
  parameter logic [LIFE_W-1:0] INIT_LIVES = 4'd3,
  parameter logic [7:0] INVULN_FRAMES = 8'd60
`ifdef LIVES_TRACKER_HEAL_EN
  , parameter logic [LIFE_W-1:0] MAX_LIVES = 4'd9
`endif
) (
  input logic Clk,
  input logic Reset,
  lives_tracker_if.slave bus
);
  state_t state, state_next;
  logic vs_q, tick, play;
  logic [1:0] hit_in, hit, act, winner, winner_next;
  logic [1:0][LIFE_W-1:0] lives, lives_next;
`ifdef LIVES_TRACKER_HEAL_EN
  logic [1:0] heal_in, heal;
  assign heal_in = {bus.p2_heal, bus.p1_heal};
`endif
  assign tick = bus.VGA_VS & ~vs_q;
  assign play = state == PLAY;
  assign hit_in = {bus.p2_hit, bus.p1_hit};
  always_comb
    state_next = (state == IDLE) ? (bus.game_on ? PLAY : IDLE)
               : (state == PLAY) ? (bus.game_over ? OVER : bus.game_on ? PLAY : IDLE)
               : ((bus.game_over || bus.game_on) ? OVER : IDLE);
  // Lives are registered, so a zero seen here is one cycle after the decrement.
  always_comb
    winner_next = (play && winner == WIN_NONE) ? winner_of(lives[0] == '0, lives[1] == '0) : winner;
  genvar p;
  for (p = 0; p < 2; p++) begin : g_player
    // act mirrors the old counter, so a hit on the tick that expires immunity is still dropped.
    assign hit[p] = play & hit_in[p] & (lives[p] != '0) & ~act[p];
`ifdef LIVES_TRACKER_HEAL_EN
    assign heal[p] = play & heal_in[p] & (lives[p] != '0);
    assign lives_next[p] = (hit[p] == heal[p]) ? lives[p]
                         : hit[p] ? lives[p] - ONE_LIFE
                         : (lives[p] < MAX_LIVES) ? lives[p] + ONE_LIFE : lives[p];
`else
    assign lives_next[p] = hit[p] ? lives[p] - ONE_LIFE : lives[p];
`endif
    invuln_timer #(.FRAMES(INVULN_FRAMES)) u_timer (
      .Clk(Clk),
      .Reset(Reset),
      .clear(state_next == IDLE),
      .load(hit[p]),
      .tick(tick & play),
      .active(act[p])
    );
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      vs_q <= 1'b0;
      lives <= {2{INIT_LIVES}};
      winner <= WIN_NONE;
    end else begin
      vs_q <= bus.VGA_VS;
      state <= state_next;
      if (state_next == IDLE) begin
        lives <= {2{INIT_LIVES}};
        winner <= WIN_NONE;
      end else if (play) begin
        lives <= lives_next;
        winner <= winner_next;
      end
    end
  assign bus.player1_lives = lives[0];
  assign bus.player2_lives = lives[1];
  assign bus.p1_invuln = act[0] & (state != OVER);
  assign bus.p2_invuln = act[1] & (state != OVER);
  assign bus.round_winner = winner;
endmodule

// File: tb/tb_lives_tracker.sv
// tb_lives_tracker: directed plus random checks of two trackers (60 and 0 immunity frames)
module tb_lives_tracker;
  import lives_tracker_pkg::*;
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;
  localparam int M_INIT = 3, M_MAX = 9;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;
  int checks = 0, errors = 0;
  logic vs = 0, gon = 0, gov = 0, h1 = 0, h2 = 0;
  logic hl1 = 0, hl2 = 0;
  lives_tracker_if ia();
  lives_tracker_if ib();
  assign ia.VGA_VS = vs;
  assign ia.game_on = gon;
  assign ia.game_over = gov;
  assign ia.p1_hit = h1;
  assign ia.p2_hit = h2;
  assign ib.VGA_VS = vs;
  assign ib.game_on = gon;
  assign ib.game_over = gov;
  assign ib.p1_hit = h1;
  assign ib.p2_hit = h2;
`ifdef LIVES_TRACKER_HEAL_EN
  assign ia.p1_heal = hl1;
  assign ia.p2_heal = hl2;
  assign ib.p1_heal = hl1;
  assign ib.p2_heal = hl2;
`endif
  lives_tracker #(.INVULN_FRAMES(8'd60)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ia));
  lives_tracker #(.INVULN_FRAMES(8'd0)) dut_b (.Clk(Clk), .Reset(Reset), .bus(ib));
  logic [3:0] o_l [2][2];
  logic o_v [2][2];
  logic [1:0] o_w [2];
  assign o_l[0][0] = ia.player1_lives;
  assign o_l[0][1] = ia.player2_lives;
  assign o_l[1][0] = ib.player1_lives;
  assign o_l[1][1] = ib.player2_lives;
  assign o_v[0][0] = ia.p1_invuln;
  assign o_v[0][1] = ia.p2_invuln;
  assign o_v[1][0] = ib.p1_invuln;
  assign o_v[1][1] = ib.p2_invuln;
  assign o_w[0] = ia.round_winner;
  assign o_w[1] = ib.round_winner;
  int fr [2] = '{60, 0};
  int m_st [2];
  int m_l [2][2];
  int m_c [2][2];
  int m_w [2];
  int vsq;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    vsq = 0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE;
      m_w[i] = 0;
      for (int p = 0; p < 2; p++) begin
        m_l[i][p] = M_INIT;
        m_c[i][p] = 0;
      end
    end
  endtask
  task automatic m_step();
    int tk, nst, hit, hl;
    int hits [2];
    int heals [2];
    int ol [2];
    tk = (vs && !vsq) ? 1 : 0;
    vsq = int'(vs);
    hits[0] = int'(h1);
    hits[1] = int'(h2);
    heals[0] = int'(hl1);
    heals[1] = int'(hl2);
`ifndef LIVES_TRACKER_HEAL_EN
    heals[0] = 0;
    heals[1] = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      ol[0] = m_l[i][0];
      ol[1] = m_l[i][1];
      if (m_st[i] == M_PLAY) begin
        for (int p = 0; p < 2; p++) begin
          hit = (hits[p] != 0 && ol[p] > 0 && m_c[i][p] == 0) ? 1 : 0;
          hl = (heals[p] != 0 && ol[p] > 0) ? 1 : 0;
          if (hit == 1 && hl == 0) m_l[i][p] = ol[p] - 1;
          else if (hl == 1 && hit == 0 && ol[p] < M_MAX) m_l[i][p] = ol[p] + 1;
          if (hit == 1) m_c[i][p] = fr[i];
          else if (tk == 1 && m_c[i][p] > 0) m_c[i][p] = m_c[i][p] - 1;
        end
        if (m_w[i] == 0 && (ol[0] == 0 || ol[1] == 0))
          m_w[i] = (ol[0] == 0 ? 2 : 0) + (ol[1] == 0 ? 1 : 0);
        nst = gov ? M_OVER : gon ? M_PLAY : M_IDLE;
      end else if (m_st[i] == M_IDLE) nst = gon ? M_PLAY : M_IDLE;
      else nst = (gov || gon) ? M_OVER : M_IDLE;
      if (nst == M_IDLE) begin
        m_w[i] = 0;
        for (int p = 0; p < 2; p++) begin
          m_l[i][p] = M_INIT;
          m_c[i][p] = 0;
        end
      end
      m_st[i] = nst;
    end
  endtask
  task automatic cmp_model();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("dut%0d_p%0d_lives", i, p + 1), 32'(o_l[i][p]), m_l[i][p]);
        check($sformatf("dut%0d_p%0d_invuln", i, p + 1), 32'(o_v[i][p]),
              (m_st[i] != M_OVER && m_c[i][p] != 0) ? 1 : 0);
      end
      check($sformatf("dut%0d_winner", i), 32'(o_w[i]), m_w[i]);
    end
  endtask
  task automatic cyc();
    @(posedge Clk);
    m_step();
    #1;
    cmp_model();
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      vs = 1;
      cyc();
      vs = 0;
      cyc();
    end
  endtask
  initial begin
    m_reset();
    #12;
    cmp_model();
    check("reset_a_p1", 32'(ia.player1_lives), 3);
    @(posedge Clk);
    #1 Reset = 1;
    gon = 1;
    cyc();
    check("play_a_p1", 32'(ia.player1_lives), 3);
    check("play_a_p2", 32'(ia.player2_lives), 3);
    check("play_a_win", 32'(ia.round_winner), 0);
    check("play_a_inv", 32'(ia.p1_invuln), 0);
    h1 = 1;
    cyc();
    h1 = 0;
    check("hit1_a_lives", 32'(ia.player1_lives), 2);
    check("hit1_a_inv", 32'(ia.p1_invuln), 1);
    check("hit1_b_inv", 32'(ib.p1_invuln), 0);
    tick_n(5);
    h1 = 1;
    cyc();
    h1 = 0;
    check("immune_a_lives", 32'(ia.player1_lives), 2);
    check("noimm_b_lives", 32'(ib.player1_lives), 1);
    tick_n(54);
    check("imm59_a_inv", 32'(ia.p1_invuln), 1);
    tick_n(1);
    check("imm60_a_inv", 32'(ia.p1_invuln), 0);
    h1 = 1;
    cyc();
    h1 = 0;
    check("hit3_a_lives", 32'(ia.player1_lives), 1);
    check("zero_b_lives", 32'(ib.player1_lives), 0);
    cyc();
    check("winp2_b", 32'(ib.round_winner), 2);
    gon = 0;
    cyc();
    check("abort_b_p1", 32'(ib.player1_lives), 3);
    check("abort_b_win", 32'(ib.round_winner), 0);
    gon = 1;
    cyc();
    repeat (2) begin
      h2 = 1;
      cyc();
      h2 = 0;
      cyc();
    end
    h2 = 1;
    cyc();
    h2 = 0;
    check("p2zero_b", 32'(ib.player2_lives), 0);
    check("p2zero_b_win", 32'(ib.round_winner), 0);
    cyc();
    check("winp1_b", 32'(ib.round_winner), 1);
    check("imm_a_p2", 32'(ia.player2_lives), 2);
    gov = 1;
    cyc();
    h1 = 1;
    cyc();
    h1 = 0;
    check("over_b_p1", 32'(ib.player1_lives), 3);
    check("over_a_p2inv", 32'(ia.p2_invuln), 0);
    check("over_b_win", 32'(ib.round_winner), 1);
    gov = 0;
    gon = 0;
    cyc();
    check("idle_b_p2", 32'(ib.player2_lives), 3);
    check("idle_b_win", 32'(ib.round_winner), 0);
    gon = 1;
    cyc();
    repeat (2) begin
      h1 = 1;
      h2 = 1;
      cyc();
      h1 = 0;
      h2 = 0;
      cyc();
    end
    h1 = 1;
    h2 = 1;
    cyc();
    h1 = 0;
    h2 = 0;
    check("draw_b_p1", 32'(ib.player1_lives), 0);
    check("draw_b_p2", 32'(ib.player2_lives), 0);
    cyc();
    check("draw_b_win", 32'(ib.round_winner), 3);
    gon = 0;
    cyc();
`ifdef LIVES_TRACKER_HEAL_EN
    gon = 1;
    cyc();
    hl1 = 1;
    repeat (7) cyc();
    hl1 = 0;
    check("heal_sat_a", 32'(ia.player1_lives), 9);
    gon = 0;
    cyc();
    gon = 1;
    cyc();
    h1 = 1;
    cyc();
    h1 = 0;
    tick_n(60);
    h1 = 1;
    hl1 = 1;
    cyc();
    h1 = 0;
    hl1 = 0;
    check("heal_cancel_a", 32'(ia.player1_lives), 2);
    check("heal_cancel_inv", 32'(ia.p1_invuln), 1);
    gon = 0;
    cyc();
`endif
    for (int n = 0; n < 4000; n++) begin
      vs = ($urandom_range(0, 3) == 0) ? ~vs : vs;
      h1 = ($urandom_range(0, 5) == 0);
      h2 = ($urandom_range(0, 5) == 0);
      hl1 = ($urandom_range(0, 7) == 0);
      hl2 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 60) == 0) gon = ~gon;
      if ($urandom_range(0, 90) == 0) gov = ~gov;
      cyc();
    end
    h1 = 0;
    h2 = 0;
    hl1 = 0;
    hl2 = 0;
    gov = 0;
    gon = 0;
    cyc();
    gon = 1;
    cyc();
    h1 = 1;
    cyc();
    h1 = 0;
    #2 Reset = 0;
    #1;
    m_reset();
    cmp_model();
    check("midrst_a_p1", 32'(ia.player1_lives), 3);
    check("midrst_a_inv", 32'(ia.p1_invuln), 0);
    gon = 0;
    @(negedge Clk);
    Reset = 1;
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lives_tracker.md
Name: lives_tracker

Overview:
- Owns both players' life counts and drives player1_lives/player2_lives into the game state FSM.
- Consumes that FSM's game_on/game_over levels, plus single-cycle hit pulses from the collision logic.
- Applies frame-based invulnerability after each hit, saturates lives at zero, and latches the round winner.
- Reloads lives when the game returns to the start page.

Parameters:
- INIT_LIVES, 4'd3, lives loaded at reset and at each return to IDLE.
- INVULN_FRAMES, 8'd60, frames of hit immunity after a counted hit; 0 disables immunity.
- MAX_LIVES, 4'd9, upper saturation bound; used only with HEAL_EN.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (name kept per codebase; 0 = reset).
- VGA_VS  in  1  vertical sync; each rising edge is one frame tick.
- game_on  in  1  level from the game FSM; high while play is active.
- game_over  in  1  level from the game FSM; high in GAME_OVER and DISAPEAR.
- p1_hit  in  1  one-cycle pulse; player 1 was struck.
- p2_hit  in  1  one-cycle pulse; player 2 was struck.
- player1_lives  out  4  current player 1 lives.
- player2_lives  out  4  current player 2 lives.
- p1_invuln  out  1  player 1 immune (drive sprite blink).
- p2_invuln  out  1  player 2 immune.
- round_winner  out  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; lives=INIT_LIVES for both players.
  - Invulnerability counters=0, invuln outputs=0, round_winner=00, frame-edge register=0.
- Frame tick:
  - vs_q registers VGA_VS; tick = VGA_VS & ~vs_q.
  - One-cycle pulse; one cycle of latency from the VGA_VS edge.
- IDLE:
  - Lives held at INIT_LIVES; hits ignored.
  - game_on=1 -> PLAY next cycle.
- PLAY:
  - A hit counts when: hit pulse=1, lives!=0, immunity counter==0.
  - A counted hit decrements lives by 1 and loads the counter with INVULN_FRAMES, both on the next clock edge.
  - Counter decrements by 1 on each tick while nonzero; pxx_invuln = (counter!=0), registered.
  - Hits during immunity are dropped (not queued).
  - Lives never wrap below 0.
  - Winner latch happens in the cycle after a decrement brings any player to 0, and only while round_winner==00:
    - only P2 at 0 -> 01; only P1 at 0 -> 10; both at 0 in the same cycle -> 11.
  - game_over=1 -> OVER. game_on=0 and game_over=0 -> IDLE (abort).
- OVER:
  - Lives, winner and counters frozen; hits ignored; invuln outputs forced to 0.
  - game_over=0 and game_on=0 -> IDLE.
- Entering IDLE from any state: lives reload to INIT_LIVES, counters clear, round_winner=00, all in the same cycle.
- Simultaneous p1_hit and p2_hit are evaluated independently; both may count.
- A hit coinciding with a tick that drives the counter to 0: the hit is still ignored, because the old counter was nonzero.
- A hit coinciding with the game_over rise: state is still PLAY, so the hit counts.
- Reset asserted mid-round: immediate return to reset values.

Optional Feature:
- Macro: LIVES_TRACKER_HEAL_EN.
- With the macro defined:
  - Adds inputs p1_heal and p2_heal (1-bit pulses).
  - In PLAY, a heal adds 1 life, saturating at MAX_LIVES.
  - A heal and a counted hit in the same cycle cancel: lives unchanged, but the immunity counter still loads.
  - Heal on a player at 0 lives is ignored.
- Without the macro: no heal ports; MAX_LIVES is unused.

Decomposition:
- lives_pkg holds:
  - state enum {IDLE, PLAY, OVER}.
  - Winner constants WIN_NONE=2'b00, WIN_P1=2'b01, WIN_P2=2'b10, WIN_DRAW=2'b11.
  - LIFE_W=4.
- Sub-module invuln_timer, instantiated once per player.
  - Inputs: Clk, Reset, clear, load, tick.
  - Output: active.
  - Contains an 8-bit down-counter.

Test Plan:
- Reset low, then high; game_on=1 -> lives 3/3 in PLAY; round_winner=00; invuln 0/0.
- PLAY, p1_hit pulse -> player1_lives=2 the next cycle; p1_invuln=1. Second p1_hit 5 ticks later -> still 2. After 60 ticks -> p1_invuln=0; next p1_hit -> 1.
- INVULN_FRAMES=0: three p2_hit pulses 2 cycles apart -> player2_lives reaches 0; round_winner=01 one cycle later.
- P1=1, P2=1, no immunity, p1_hit and p2_hit in the same cycle -> both lives 0, round_winner=11.
- After the winner latches: game_over=1, then p1_hit -> lives unchanged. game_over=0 with game_on=0 -> IDLE, lives 3/3, winner 00.
- LIVES_TRACKER_HEAL_EN: P1 at 9, p1_heal -> stays 9. P1 at 2 with p1_heal and counted p1_hit together -> stays 2, p1_invuln=1.
